// File: rtl/spi_master_param.sv
// Parametrised full-duplex SPI master: one DATA_W-bit transfer per start request,
// runtime CPOL/CPHA, programmable SCK half-period and one-hot active-low chip selects.
module spi_master_param #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned NUM_CS = 2,
    parameter int unsigned DIV_W  = 8,
    localparam int unsigned CS_W  = (NUM_CS > 1) ? $clog2(NUM_CS) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [CS_W-1:0]   cs_sel,
    input  logic              cpol,
    input  logic              cpha,
    input  logic [DIV_W-1:0]  clk_div,
    input  logic [DATA_W-1:0] tx_data,
    output logic [DATA_W-1:0] rx_data,
    output logic              busy,
    output logic              done,
    output logic              sck_o,
    output logic              mosi_o,
    input  logic              miso_i,
    output logic [NUM_CS-1:0] cs_n_o
);

    localparam int unsigned EDGE_W = $clog2(2 * DATA_W + 1);
    localparam logic [EDGE_W-1:0] LAST_EDGE = EDGE_W'(2 * DATA_W - 1);

    typedef enum logic [1:0] {IDLE, SETUP, XFER, HOLD} state_e;

    state_e              state_q, state_d;
    logic [DIV_W-1:0]    cnt_q, cnt_d;
    logic [DIV_W-1:0]    div_q, div_d;
    logic [EDGE_W-1:0]   edge_q, edge_d;
    logic                cpol_q, cpol_d;
    logic                cpha_q, cpha_d;
    logic [DATA_W-1:0]   sh_q, sh_d;
    logic [DATA_W-1:0]   rx_sh_q, rx_sh_d;
    logic [DATA_W-1:0]   rx_q, rx_d;
    logic [NUM_CS-1:0]   cs_n_q, cs_n_d;
    logic                sck_q, sck_d;
    logic                mosi_q, mosi_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic [NUM_CS-1:0]   cs_dec;
    logic                half_end;
    logic                leading;

    // Out-of-range selects match no bit, so every chip select stays high.
    always_comb begin
        cs_dec = '1;
        for (int unsigned i = 0; i < NUM_CS; i++) begin
            if (cs_sel == CS_W'(i)) cs_dec[i] = 1'b0;
        end
    end

    assign half_end = (cnt_q == div_q);
    assign leading  = ~edge_q[0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            div_q   <= '0;
            edge_q  <= '0;
            cpol_q  <= 1'b0;
            cpha_q  <= 1'b0;
            sh_q    <= '0;
            rx_sh_q <= '0;
            rx_q    <= '0;
            cs_n_q  <= '1;
            sck_q   <= 1'b0;
            mosi_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            div_q   <= div_d;
            edge_q  <= edge_d;
            cpol_q  <= cpol_d;
            cpha_q  <= cpha_d;
            sh_q    <= sh_d;
            rx_sh_q <= rx_sh_d;
            rx_q    <= rx_d;
            cs_n_q  <= cs_n_d;
            sck_q   <= sck_d;
            mosi_q  <= mosi_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = (state_q == IDLE || half_end) ? '0 : cnt_q + DIV_W'(1);
        div_d   = div_q;
        edge_d  = edge_q;
        cpol_d  = cpol_q;
        cpha_d  = cpha_q;
        sh_d    = sh_q;
        rx_sh_d = rx_sh_q;
        rx_d    = rx_q;
        cs_n_d  = cs_n_q;
        sck_d   = sck_q;
        mosi_d  = mosi_q;
        busy_d  = busy_q;
        done_d  = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = SETUP;
                    div_d   = clk_div;
                    cpol_d  = cpol;
                    cpha_d  = cpha;
                    sh_d    = tx_data;
                    rx_sh_d = '0;
                    edge_d  = '0;
                    cs_n_d  = cs_dec;
                    sck_d   = cpol;
                    busy_d  = 1'b1;
                    if (!cpha) mosi_d = tx_data[DATA_W-1];
                end
            end
            SETUP: begin
                if (half_end) state_d = XFER;
            end
            XFER: begin
                if (half_end) begin
                    edge_d = edge_q + EDGE_W'(1);
                    sck_d  = ~sck_q;
                    // CPHA selects which edge samples; the other edge launches data.
                    if (leading == cpha_q) begin
                        if (edge_q != LAST_EDGE) begin
                            mosi_d = cpha_q ? sh_q[DATA_W-1] : sh_q[DATA_W-2];
                            sh_d   = {sh_q[DATA_W-2:0], 1'b0};
                        end
                    end else begin
                        rx_sh_d = {rx_sh_q[DATA_W-2:0], miso_i};
                    end
                    if (edge_q == LAST_EDGE) begin
                        sck_d   = cpol_q;
                        state_d = HOLD;
                    end
                end
            end
            HOLD: begin
                if (half_end) begin
                    state_d = IDLE;
                    cs_n_d  = '1;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    rx_d    = rx_sh_q;
                    mosi_d  = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign rx_data = rx_q;
    assign busy    = busy_q;
    assign done    = done_q;
    assign sck_o   = sck_q;
    assign mosi_o  = mosi_q;
    assign cs_n_o  = cs_n_q;

endmodule

// File: tb/tb_spi_master_param.sv
// Bench for spi_master_param: cycle-level reference model of the SPI waveform,
// a simple SPI slave, and directed transfers with literal expectations.
module tb_spi_master_param;

    localparam int unsigned DATA_W = 8;
    localparam int unsigned NUM_CS = 2;
    localparam int unsigned DIV_W  = 8;
    localparam int          NB     = 8;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start = 1'b0;
    logic [0:0]        cs_sel = 1'b0;
    logic              cpol = 1'b0;
    logic              cpha = 1'b0;
    logic [DIV_W-1:0]  clk_div = '0;
    logic [DATA_W-1:0] tx_data = '0;
    logic [DATA_W-1:0] rx_data;
    logic              busy, done, sck_o, mosi_o;
    logic              miso_i;
    logic [NUM_CS-1:0] cs_n_o;

    // Second instance with three selects so an out-of-range index is representable.
    logic              start3 = 1'b0;
    logic [1:0]        cs_sel3 = 2'd0;
    logic [DATA_W-1:0] rx3;
    logic              busy3, done3, sck3, mosi3;
    logic              miso3 = 1'b0;
    logic [2:0]        cs_n3;

    logic              loop_en = 1'b1;
    logic [7:0]        slv_word = 8'h00;
    logic              slv_bit = 1'b0;

    int n_checks = 0;
    int n_err    = 0;

    assign miso_i = loop_en ? mosi_o : slv_bit;

    always #5 clk = ~clk;

    spi_master_param #(.DATA_W(DATA_W), .NUM_CS(NUM_CS), .DIV_W(DIV_W)) u_dut (
        .clk(clk), .rst_n(rst_n), .start(start), .cs_sel(cs_sel), .cpol(cpol),
        .cpha(cpha), .clk_div(clk_div), .tx_data(tx_data), .rx_data(rx_data),
        .busy(busy), .done(done), .sck_o(sck_o), .mosi_o(mosi_o),
        .miso_i(miso_i), .cs_n_o(cs_n_o)
    );

    spi_master_param #(.DATA_W(DATA_W), .NUM_CS(3), .DIV_W(DIV_W)) u_dut3 (
        .clk(clk), .rst_n(rst_n), .start(start3), .cs_sel(cs_sel3), .cpol(cpol),
        .cpha(cpha), .clk_div(clk_div), .tx_data(tx_data), .rx_data(rx3),
        .busy(busy3), .done(done3), .sck_o(sck3), .mosi_o(mosi3),
        .miso_i(miso3), .cs_n_o(cs_n3)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a transfer is j cycles old; every h=clk_div+1 cycles one phase ends.
    bit                m_act = 1'b0;
    int                m_j = 0;
    int                m_L = 0;
    logic              m_pol = 1'b0;
    logic              m_pha = 1'b0;
    logic [7:0]        m_tx = '0;
    logic [7:0]        m_word = '0;
    logic [7:0]        m_rx = '0;
    logic [NUM_CS-1:0] m_cs = '1;

    initial begin
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                m_act = 1'b0; m_pol = 1'b0; m_rx = '0;
            end else if ((!m_act || m_j == m_L) && start) begin
                m_act  = 1'b1;
                m_j    = 0;
                m_L    = (2 * NB + 2) * (int'(clk_div) + 1);
                m_pol  = cpol;
                m_pha  = cpha;
                m_tx   = tx_data;
                m_word = loop_en ? tx_data : slv_word;
                m_cs   = (int'(cs_sel) < int'(NUM_CS)) ? ~(NUM_CS'(1) << cs_sel) : '1;
            end else if (m_act) begin
                if (m_j == m_L) m_act = 1'b0;
                else begin
                    m_j = m_j + 1;
                    if (m_j == m_L) m_rx = m_word;
                end
            end
        end
    end

    // Compare every output of the main instance against the model on each falling edge.
    initial begin
        int h, e, bi;
        logic xs, xm;
        forever begin
            @(negedge clk);
            chk("rx_data", 32'(rx_data), 32'(m_rx));
            if (m_act && m_j < m_L) begin
                h = m_L / (2 * NB + 2);
                e = (m_j < h) ? 0 : m_j / h - 1;
                if (e > 2 * NB) e = 2 * NB;
                xs = m_pol ^ (e % 2 == 1);
                if (!m_pha) begin
                    bi = NB - 1 - ((e / 2 > NB - 1) ? NB - 1 : e / 2);
                    xm = m_tx[bi];
                end else begin
                    xm = (e == 0) ? 1'b0 : m_tx[NB - (e + 1) / 2];
                end
                chk("busy", 32'(busy), 32'd1);
                chk("done", 32'(done), 32'd0);
                chk("cs_n", 32'(cs_n_o), 32'(m_cs));
                chk("sck", 32'(sck_o), 32'(xs));
                chk("mosi", 32'(mosi_o), 32'(xm));
            end else begin
                chk("busy", 32'(busy), 32'd0);
                chk("done", 32'(done), 32'(m_act && m_j == m_L));
                chk("cs_n", 32'(cs_n_o), 32'(2'b11));
                chk("sck", 32'(sck_o), 32'(m_pol));
                chk("mosi", 32'(mosi_o), 32'd0);
            end
        end
    end

    // SPI slave on cs 0: MSB on CS fall (CPHA=0) or first leading edge (CPHA=1).
    initial begin
        logic pcs, psck;
        int   idx, ne;
        pcs = 1'b1; psck = 1'b0; idx = -1; ne = 0;
        forever begin
            @(posedge clk);
            #1;
            if (pcs && !cs_n_o[0]) begin
                idx = 7; ne = 0;
                if (!cpha) begin slv_bit = slv_word[7]; idx = 6; end
            end else if (!cs_n_o[0] && sck_o !== psck) begin
                ne++;
                if (((ne % 2) == 1) == cpha && idx >= 0) begin
                    slv_bit = slv_word[idx];
                    idx--;
                end
            end
            pcs = cs_n_o[0]; psck = sck_o;
        end
    end

    // Issue one transfer from a falling edge and follow it to its done pulse.
    task automatic do_xfer(input logic pol, input logic pha, input logic [DIV_W-1:0] div,
                           input logic [7:0] tx, input int restart_at,
                           output int lat, output int nedge, output logic [7:0] mbits,
                           output logic [NUM_CS-1:0] cs_seen);
        logic psck;
        cpol = pol; cpha = pha; clk_div = div; tx_data = tx; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("busy_rise", 32'(busy), 32'd1);
        cs_seen = cs_n_o; psck = sck_o; lat = 0; nedge = 0; mbits = '0;
        while (!done && lat < 6000) begin
            @(negedge clk);
            lat++;
            if (restart_at != 0 && lat == restart_at - 1) begin tx_data = 8'hFF; start = 1'b1; end
            if (restart_at != 0 && lat == restart_at) start = 1'b0;
            if (sck_o !== psck) begin
                nedge++;
                if (sck_o !== pol) mbits = {mbits[6:0], mosi_o};
            end
            psck = sck_o;
        end
        if (!done) chk("done_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        int lat, ne, extra, csbad;
        logic [7:0] mb;
        logic [NUM_CS-1:0] cs_seen;
        logic [1:0] md;

        repeat (3) @(negedge clk);
        chk("rst_rx", 32'(rx_data), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_sck", 32'(sck_o), 32'd0);
        chk("rst_mosi", 32'(mosi_o), 32'd0);
        chk("rst_cs", 32'(cs_n_o), 32'(2'b11));
        rst_n = 1'b1;
        @(negedge clk);

        // Mode 0 loopback.
        do_xfer(1'b0, 1'b0, 8'd1, 8'hA5, 0, lat, ne, mb, cs_seen);
        chk("m0_latency", 32'(lat), 32'd36);
        chk("m0_mosi_bits", 32'(mb), 32'hA5);
        chk("m0_cs", 32'(cs_seen), 32'(2'b10));
        chk("m0_rx", 32'(rx_data), 32'hA5);
        chk("m0_edges", 32'(ne), 32'd16);

        // Modes 1..3 against the slave.
        loop_en = 1'b0; slv_word = 8'hC3;
        for (int m = 1; m < 4; m++) begin
            md = 2'(m);
            repeat (2) @(negedge clk);
            do_xfer(md[1], md[0], 8'd2, 8'h3C, 0, lat, ne, mb, cs_seen);
            chk("slave_rx", 32'(rx_data), 32'hC3);
            chk("slave_edges", 32'(ne), 32'd16);
            @(negedge clk);
            chk("sck_idle", 32'(sck_o), 32'(md[1]));
        end

        // Start while busy is ignored.
        loop_en = 1'b1;
        repeat (2) @(negedge clk);
        do_xfer(1'b0, 1'b0, 8'd1, 8'h5A, 5, lat, ne, mb, cs_seen);
        chk("ign_rx", 32'(rx_data), 32'h5A);
        chk("ign_latency", 32'(lat), 32'd36);
        extra = 0;
        repeat (40) begin
            @(negedge clk);
            if (done) extra++;
        end
        chk("ign_extra_done", 32'(extra), 32'd0);

        // Maximum rate, second start issued in the done cycle.
        do_xfer(1'b0, 1'b0, 8'd0, 8'h69, 0, lat, ne, mb, cs_seen);
        chk("b2b_lat1", 32'(lat), 32'd18);
        chk("b2b_rx1", 32'(rx_data), 32'h69);
        do_xfer(1'b0, 1'b0, 8'd0, 8'h96, 0, lat, ne, mb, cs_seen);
        chk("b2b_lat2", 32'(lat), 32'd18);
        chk("b2b_rx2", 32'(rx_data), 32'h96);

        // Out-of-range chip select on the three-select instance.
        @(negedge clk);
        clk_div = 8'd1; cs_sel3 = 2'd3; start3 = 1'b1;
        @(negedge clk);
        start3 = 1'b0;
        chk("cs3_busy", 32'(busy3), 32'd1);
        begin
            logic ps;
            ps = sck3; lat = 0; ne = 0; csbad = 0;
            while (!done3 && lat < 1000) begin
                @(negedge clk);
                lat++;
                if (sck3 !== ps) ne++;
                ps = sck3;
                if (cs_n3 !== 3'b111) csbad++;
            end
        end
        chk("cs3_done", 32'(done3), 32'd1);
        chk("cs3_edges", 32'(ne), 32'd16);
        chk("cs3_cs_bad", 32'(csbad), 32'd0);
        chk("cs3_latency", 32'(lat), 32'd36);

        // Reset after the 6th SCK edge of a CPOL=1 transfer.
        @(negedge clk);
        cpol = 1'b1; cpha = 1'b0; clk_div = 8'd1; tx_data = 8'hE7; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        begin
            logic ps;
            ps = sck_o; ne = 0; lat = 0;
            while (ne < 6 && lat < 200) begin
                @(negedge clk);
                lat++;
                if (sck_o !== ps) ne++;
                ps = sck_o;
            end
        end
        chk("rst_edge_reached", 32'(ne), 32'd6);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_sck", 32'(sck_o), 32'd0);
        chk("arst_cs", 32'(cs_n_o), 32'(2'b11));
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_rx", 32'(rx_data), 32'd0);
        chk("arst_done", 32'(done), 32'd0);
        chk("arst_mosi", 32'(mosi_o), 32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        do_xfer(1'b1, 1'b0, 8'd1, 8'h96, 0, lat, ne, mb, cs_seen);
        chk("post_rst_rx", 32'(rx_data), 32'h96);
        chk("post_rst_lat", 32'(lat), 32'd36);

        // Largest divider.
        @(negedge clk);
        do_xfer(1'b1, 1'b1, 8'hFF, 8'h81, 0, lat, ne, mb, cs_seen);
        chk("maxdiv_lat", 32'(lat), 32'd4608);
        chk("maxdiv_rx", 32'(rx_data), 32'h81);

        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
